video_timing: RTL and testbench

Raster timing generator and pixel output stage for the VGA path. It produces the `hdata`/`vdata` raster coordinates that drive every layer's transformer and VRAM lookup. It receives the final composited pixel back from the end of the layer chain, re-aligns the sync signals to the layer pipeline latency, and drives the VGA pins with blanking and background substitution. It also emits a once-per-frame tick for game logic to update layer offsets.

---
 rtl/video_timing.sv | 138 +++++++++++++
 tb/tb_video_timing.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// rtl/video_timing.sv - VGA raster counters, sync alignment and pixel output stage
// Optional colour-bar generator enabled by defining VIDEO_TEST_PATTERN_EN.
module video_timing #(
  parameter int          HWIDTH     = 12,
  parameter int          VWIDTH     = 12,
  parameter int          DATA_WIDTH = 13,
  parameter int          HSIZE      = 640,
  parameter int          HFP        = 16,
  parameter int          HSYNC      = 96,
  parameter int          HBP        = 48,
  parameter int          VSIZE      = 480,
  parameter int          VFP        = 10,
  parameter int          VSYNC      = 2,
  parameter int          VBP        = 33,
  parameter int          LATENCY    = 1,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic                  test_en,
`endif
  output logic [HWIDTH-1:0]     hdata,
  output logic [VWIDTH-1:0]     vdata,
  output logic                  frame,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b
);

  localparam int HTOTAL = HSIZE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VSIZE + VFP + VSYNC + VBP;

  localparam logic [HWIDTH-1:0] H_LAST     = HWIDTH'(HTOTAL - 1);
  localparam logic [HWIDTH-1:0] H_ACT      = HWIDTH'(HSIZE);
  localparam logic [HWIDTH-1:0] HS_START   = HWIDTH'(HSIZE + HFP);
  localparam logic [HWIDTH-1:0] HS_END     = HWIDTH'(HSIZE + HFP + HSYNC);
  localparam logic [VWIDTH-1:0] V_LAST     = VWIDTH'(VTOTAL - 1);
  localparam logic [VWIDTH-1:0] V_ACT      = VWIDTH'(VSIZE);
  localparam logic [VWIDTH-1:0] VS_START   = VWIDTH'(VSIZE + VFP);
  localparam logic [VWIDTH-1:0] VS_END     = VWIDTH'(VSIZE + VFP + VSYNC);

  logic [HWIDTH-1:0] hcount;
  logic [VWIDTH-1:0] vcount;
  logic              active_raw;
  logic              hs_raw;
  logic              vs_raw;
  logic              act_d [LATENCY];
  logic              hs_d  [LATENCY];
  logic              vs_d  [LATENCY];
  logic [11:0]       color;

  // A single wrap of hcount at the last line also wraps vcount, giving (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + VWIDTH'(1);
    end else begin
      hcount <= hcount + HWIDTH'(1);
    end
  end

  assign hdata      = hcount;
  assign vdata      = vcount;
  assign active_raw = (hcount < H_ACT) && (vcount < V_ACT);
  assign hs_raw     = (hcount >= HS_START) && (hcount < HS_END);
  assign vs_raw     = (vcount >= VS_START) && (vcount < VS_END);

  // Flags ride alongside the layer pipeline so they meet the matching pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        act_d[i] <= 1'b0;
        hs_d[i]  <= 1'b0;
        vs_d[i]  <= 1'b0;
      end
    end else begin
      act_d[0] <= active_raw;
      hs_d[0]  <= hs_raw;
      vs_d[0]  <= vs_raw;
      for (int i = 1; i < LATENCY; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
    end
  end

`ifdef VIDEO_TEST_PATTERN_EN
  localparam logic [HWIDTH-1:0] BAR_W = HWIDTH'(HSIZE / 8);

  logic [HWIDTH-1:0] hpos_d [LATENCY];
  logic [2:0]        bar;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) hpos_d[i] <= '0;
    end else begin
      hpos_d[0] <= hcount;
      for (int i = 1; i < LATENCY; i++) hpos_d[i] <= hpos_d[i-1];
    end
  end

  assign bar = 3'(hpos_d[LATENCY-1] / BAR_W);
`endif

  always_comb begin
    color = 12'h000;
    if (act_d[LATENCY-1]) begin
      color = pixel[12] ? pixel[11:0] : BG_COLOR;
`ifdef VIDEO_TEST_PATTERN_EN
      if (test_en) color = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hsync             <= ~SYNC_POL;
      vga_vsync             <= ~SYNC_POL;
      frame                 <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= color;
      vga_hsync             <= hs_d[LATENCY-1] ? SYNC_POL : ~SYNC_POL;
      vga_vsync             <= vs_d[LATENCY-1] ? SYNC_POL : ~SYNC_POL;
      frame                 <= (hcount == '0) && (vcount == V_ACT);
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - randomized checks of video_timing against an index-arithmetic raster model
module tb_video_timing;

  localparam int HSIZE = 40, HFP = 4, HSYNC = 8, HBP = 4;
  localparam int VSIZE = 20, VFP = 2, VSYNC = 2, VBP = 3;
  localparam int LAT = 2;
  localparam int HT = HSIZE + HFP + HSYNC + HBP;
  localparam int VT = VSIZE + VFP + VSYNC + VBP;
  localparam int FT = HT * VT;
  localparam logic [11:0] BG = 12'h35A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] pixel = 13'h0;
  logic [11:0] hdata, vdata;
  logic        frame, vga_hsync, vga_vsync;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VIDEO_TEST_PATTERN_EN
  logic        test_en = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [12:0] pix_hist [0:8191];

  always #5 clk = ~clk;

  video_timing #(
    .HSIZE(HSIZE), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VSIZE(VSIZE), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
    .LATENCY(LAT), .BG_COLOR(BG), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef VIDEO_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .hdata(hdata),
    .vdata(vdata),
    .frame(frame),
    .pixel(pixel),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b)
  );

  // Coordinate presented in cycle idx after reset release.
  function automatic int eh(int idx); return idx % HT; endfunction
  function automatic int ev(int idx); return (idx / HT) % VT; endfunction

  // Pins in cycle c show coordinate c-1-LAT combined with the pixel driven in cycle c-1.
  function automatic logic [11:0] exp_rgb(int c);
    int j = c - 1 - LAT;
    logic [12:0] p;
    if (j < 0) return 12'h000;
    if (!(eh(j) < HSIZE && ev(j) < VSIZE)) return 12'h000;
    p = pix_hist[c-1];
    return p[12] ? p[11:0] : BG;
  endfunction

  function automatic logic exp_hs(int c);
    int j = c - 1 - LAT;
    if (j < 0) return 1'b1;
    return (eh(j) >= HSIZE + HFP && eh(j) < HSIZE + HFP + HSYNC) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_vs(int c);
    int j = c - 1 - LAT;
    if (j < 0) return 1'b1;
    return (ev(j) >= VSIZE + VFP && ev(j) < VSIZE + VFP + VSYNC) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_frame(int c);
    if (c < 1) return 1'b0;
    return (eh(c-1) == 0) && (ev(c-1) == VSIZE);
  endfunction

  task automatic advance(input logic [12:0] p);
    pixel = p;
    pix_hist[cyc] = p;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pixel = 13'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (hdata !== 12'd0 || vdata !== 12'd0) begin
      n_fail++; $display("FAIL reset_coord: got (%0d,%0d) want (0,0)", hdata, vdata);
    end
    n_checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      n_fail++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b});
    end
    n_checks++;
    if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || frame !== 1'b0) begin
      n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b frame=%b want 1 1 0", vga_hsync, vga_vsync, frame);
    end
    rst = 1'b0;
    cyc = 0;
    n_checks++;
    if (hdata !== 12'd0) begin
      n_fail++; $display("FAIL release_h0: got %0d want 0", hdata);
    end
    advance(13'h0);
    n_checks++;
    if (hdata !== 12'd1) begin
      n_fail++; $display("FAIL release_h1: got %0d want 1", hdata);
    end
  endtask

  task automatic test_random_frames();
    int nframes = 0;
    do_reset();
    repeat (2 * FT) begin
      n_checks++;
      if (int'(hdata) !== eh(cyc) || int'(vdata) !== ev(cyc)) begin
        n_fail++; $display("FAIL coord c=%0d: got (%0d,%0d) want (%0d,%0d)", cyc, hdata, vdata, eh(cyc), ev(cyc));
      end
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb(cyc)) begin
        n_fail++; $display("FAIL rgb c=%0d: got %h want %h", cyc, {vga_r, vga_g, vga_b}, exp_rgb(cyc));
      end
      n_checks++;
      if (vga_hsync !== exp_hs(cyc) || vga_vsync !== exp_vs(cyc)) begin
        n_fail++; $display("FAIL sync c=%0d: got hs=%b vs=%b want hs=%b vs=%b", cyc, vga_hsync, vga_vsync, exp_hs(cyc), exp_vs(cyc));
      end
      n_checks++;
      if (frame !== exp_frame(cyc)) begin
        n_fail++; $display("FAIL frame c=%0d: got %b want %b", cyc, frame, exp_frame(cyc));
      end
      if (frame === 1'b1) nframes++;
      advance(13'($urandom));
    end
    n_checks++;
    if (nframes !== 2) begin
      n_fail++; $display("FAIL frame_count: got %0d want 2", nframes);
    end
  endtask

  task automatic test_alignment();
    do_reset();
    repeat (LAT + 5) begin
      if (cyc == LAT + 1) begin
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 12'hABC) begin
          n_fail++; $display("FAIL align_hit: got %h want abc", {vga_r, vga_g, vga_b});
        end
      end
      if (cyc == LAT + 2) begin
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== BG) begin
          n_fail++; $display("FAIL align_next: got %h want %h", {vga_r, vga_g, vga_b}, BG);
        end
      end
      if (cyc == LAT) begin
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
          n_fail++; $display("FAIL align_prev: got %h want 000", {vga_r, vga_g, vga_b});
        end
      end
      advance(cyc == LAT ? 13'h1ABC : 13'h0000);
    end
  endtask

  task automatic test_bg_blank();
    int hbg = 3 + LAT;
    int hbl = HSIZE + 5 + LAT;
    do_reset();
    repeat (hbl + 3) begin
      if (cyc == hbg + 1) begin
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== BG) begin
          n_fail++; $display("FAIL bg_sub: got %h want %h", {vga_r, vga_g, vga_b}, BG);
        end
      end
      if (cyc == hbl + 1) begin
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
          n_fail++; $display("FAIL blanking: got %h want 000", {vga_r, vga_g, vga_b});
        end
      end
      if (cyc == hbg)      advance(13'h0FFF);
      else if (cyc == hbl) advance(13'h1FFF);
      else                 advance({1'b1, 12'($urandom)});
    end
  endtask

  task automatic test_mid_reset();
    int target = (VSIZE / 2) * HT + HSIZE / 2;
    int seen = -1;
    do_reset();
    while (cyc < target) advance({1'b1, 12'($urandom)});
    n_checks++;
    if (int'(hdata) !== HSIZE / 2 || int'(vdata) !== VSIZE / 2) begin
      n_fail++; $display("FAIL mid_pos: got (%0d,%0d) want (%0d,%0d)", hdata, vdata, HSIZE / 2, VSIZE / 2);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (hdata !== 12'd0 || vdata !== 12'd0 || {vga_r, vga_g, vga_b} !== 12'h000 ||
        vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || frame !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_vals: got (%0d,%0d) rgb=%h hs=%b vs=%b fr=%b want (0,0) 000 1 1 0",
                         hdata, vdata, {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, frame);
    end
    rst = 1'b0;
    cyc = 0;
    n_checks++;
    if (hdata !== 12'd0 || vdata !== 12'd0) begin
      n_fail++; $display("FAIL mid_resume: got (%0d,%0d) want (0,0)", hdata, vdata);
    end
    while (cyc < VSIZE * HT + 20 && seen < 0) begin
      if (frame === 1'b1) seen = cyc;
      else advance(13'($urandom));
    end
    n_checks++;
    if (seen !== VSIZE * HT + 1) begin
      n_fail++; $display("FAIL mid_frame_delay: got %0d want %0d", seen, VSIZE * HT + 1);
    end
  endtask

  initial begin
    test_reset();
    test_random_frames();
    test_alignment();
    test_bg_blank();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
